// File: rtl/exu_redirect_ctrl_pkg.sv
// Shared types and constants for the execute-stage redirect sequencer.
package exu_redirect_ctrl_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 32;
  localparam logic        JumpEnable      = 1'b1;
  localparam logic        JumpDisable     = 1'b0;
  localparam logic [31:0] ZeroWord        = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_INT   = 2'd0,
    SRC_BRU   = 2'd1,
    SRC_FENCE = 2'd2
  } src_e;

endpackage

// File: rtl/exu_redirect_ctrl_arb.sv
// Fixed-priority redirect source picker: interrupt > branch unit > fence.
module redirect_arb
  import exu_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              int_req,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic              bru_req,
  input  logic [ADDR_W-1:0] bru_addr,
  input  logic              fence_req,
  input  logic [ADDR_W-1:0] fence_addr,
  output logic [2:0]        grant,
  output logic [ADDR_W-1:0] sel_addr
);

  always_comb begin
    grant    = '0;
    sel_addr = '0;
    if (int_req) begin
      grant[SRC_INT] = JumpEnable;
      sel_addr       = int_addr;
    end else if (bru_req) begin
      grant[SRC_BRU] = JumpEnable;
      sel_addr       = bru_addr;
    end else if (fence_req) begin
      grant[SRC_FENCE] = JumpEnable;
      sel_addr         = fence_addr;
    end
  end

endmodule

// File: rtl/exu_redirect_ctrl.sv
// Redirect sequencer: arbitrates redirect sources, flushes the front end for a
// fixed number of cycles, then hands the latched target to fetch via valid/ready.
module exu_redirect_ctrl
  import exu_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  output logic              int_ack_o,
  input  logic              bru_jump_flag_i,
  input  logic [ADDR_W-1:0] bru_jump_addr_i,
  input  logic              fence_req_i,
  input  logic [ADDR_W-1:0] fence_addr_i,
  output logic              flush_o,
  output logic              busy_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  input  logic              redirect_ready_i,
  output logic [31:0]       redirect_cnt_o
);

  state_e            state_q;
  logic [3:0]        flush_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rcnt_q;

  logic [2:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              is_idle;
  logic              take;
  logic              handshake;

  redirect_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .int_req    (int_req_i),
    .int_addr   (int_addr_i),
    .bru_req    (bru_jump_flag_i),
    .bru_addr   (bru_jump_addr_i),
    .fence_req  (fence_req_i),
    .fence_addr (fence_addr_i),
    .grant      (grant),
    .sel_addr   (sel_addr)
  );

  assign is_idle   = (state_q == ST_IDLE);
  assign take      = is_idle & (|grant);
  assign handshake = (state_q == ST_REDIRECT) & redirect_ready_i;

  // Ack is taken straight from the interrupt grant so it only sees state and int_req_i.
  assign int_ack_o        = is_idle & grant[SRC_INT];
  assign flush_o          = (state_q == ST_FLUSH);
  assign redirect_valid_o = (state_q == ST_REDIRECT);
  assign busy_o           = flush_o | redirect_valid_o;
  assign redirect_addr_o  = redirect_valid_o ? addr_q : '0;
  assign redirect_cnt_o   = rcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      addr_q      <= '0;
      rcnt_q      <= ZeroWord;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            addr_q      <= {sel_addr[ADDR_W-1:1], 1'b0};
            flush_cnt_q <= 4'(FLUSH_CYCLES);
            state_q     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 4'd1;
          if (flush_cnt_q == 4'd1) state_q <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (handshake) begin
            rcnt_q  <= rcnt_q + 32'd1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Scoreboard bench for exu_redirect_ctrl: directed stimulus, handshake monitor.
module tb_exu_redirect_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned FC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          int_req_i = 1'b0;
  logic [AW-1:0] int_addr_i = '0;
  logic          int_ack_o;
  logic          bru_jump_flag_i = 1'b0;
  logic [AW-1:0] bru_jump_addr_i = '0;
  logic          fence_req_i = 1'b0;
  logic [AW-1:0] fence_addr_i = '0;
  logic          flush_o;
  logic          busy_o;
  logic          redirect_valid_o;
  logic [AW-1:0] redirect_addr_o;
  logic          redirect_ready_i = 1'b0;
  logic [31:0]   redirect_cnt_o;

  exu_redirect_ctrl #(
    .ADDR_W       (AW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .int_req_i        (int_req_i),
    .int_addr_i       (int_addr_i),
    .int_ack_o        (int_ack_o),
    .bru_jump_flag_i  (bru_jump_flag_i),
    .bru_jump_addr_i  (bru_jump_addr_i),
    .fence_req_i      (fence_req_i),
    .fence_addr_i     (fence_addr_i),
    .flush_o          (flush_o),
    .busy_o           (busy_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_addr_o  (redirect_addr_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_cnt_o   (redirect_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_cnt = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  // Handshake monitor: each completed transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && redirect_valid_o && redirect_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL hs_unexpected: got addr %0h, expected no handshake", redirect_addr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hs_addr", 64'(redirect_addr_o), 64'(e.addr));
        chk("hs_cnt", 64'(redirect_cnt_o), 64'(e.cnt));
      end
    end
  end

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while (busy_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(busy_o), 64'd0);
  endtask

  // Full branch redirect with ready held high, checking per-cycle timing.
  task automatic run_bru(input logic [31:0] a, input logic [31:0] ea);
    @(negedge clk);
    bru_jump_flag_i = 1'b1;
    bru_jump_addr_i = a;
    push(ea);
    @(posedge clk); #1;
    bru_jump_flag_i = 1'b0;
    for (int i = 1; i <= int'(FC); i++) begin
      chk("seq_flush", 64'(flush_o), 64'd1);
      chk("seq_valid_lo", 64'(redirect_valid_o), 64'd0);
      chk("seq_busy", 64'(busy_o), 64'd1);
      @(posedge clk); #1;
    end
    chk("seq_flush_end", 64'(flush_o), 64'd0);
    chk("seq_valid", 64'(redirect_valid_o), 64'd1);
    chk("seq_addr", 64'(redirect_addr_o), 64'(ea));
    @(posedge clk); #1;
    chk("seq_busy_lo", 64'(busy_o), 64'd0);
    chk("seq_valid_end", 64'(redirect_valid_o), 64'd0);
    chk("seq_cnt", 64'(redirect_cnt_o), 64'(exp_cnt));
  endtask

  task automatic chk_reset_outs();
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(redirect_valid_o), 64'd0);
    chk("rst_addr", 64'(redirect_addr_o), 64'd0);
    chk("rst_cnt", 64'(redirect_cnt_o), 64'd0);
    chk("rst_ack", 64'(int_ack_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    redirect_ready_i = 1'b1;

    // Basic branch redirect
    run_bru(32'h0000_1234, 32'h0000_1234);

    // Simultaneous interrupt, branch and fence
    @(negedge clk);
    int_req_i = 1'b1; int_addr_i = 32'h8000_0000;
    bru_jump_flag_i = 1'b1; bru_jump_addr_i = 32'h0000_0100;
    fence_req_i = 1'b1; fence_addr_i = 32'h0000_0204;
    push(32'h8000_0000);
    #1;
    chk("sim_ack_T", 64'(int_ack_o), 64'd1);
    @(posedge clk); #1;
    int_req_i = 1'b0; bru_jump_flag_i = 1'b0; fence_req_i = 1'b0;
    #1;
    chk("sim_ack_T1", 64'(int_ack_o), 64'd0);
    chk("sim_flush", 64'(flush_o), 64'd1);
    wait_idle("sim_idle");
    chk("sim_q_empty", 64'(exp_q.size()), 64'd0);
    chk("sim_cnt", 64'(redirect_cnt_o), 64'd2);

    // Backpressure with a ready pulse during FLUSH and injected branches
    @(negedge clk);
    redirect_ready_i = 1'b0;
    bru_jump_flag_i = 1'b1; bru_jump_addr_i = 32'h0000_0040;
    push(32'h0000_0040);
    @(posedge clk); #1;
    bru_jump_flag_i = 1'b0;
    redirect_ready_i = 1'b1;
    @(posedge clk); #1;
    redirect_ready_i = 1'b0;
    chk("bp_flush", 64'(flush_o), 64'd1);
    @(posedge clk); #1;
    chk("bp_valid0", 64'(redirect_valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      bru_jump_flag_i = 1'b1; bru_jump_addr_i = 32'h0000_0998;
      @(posedge clk); #1;
      chk("bp_valid", 64'(redirect_valid_o), 64'd1);
      chk("bp_addr", 64'(redirect_addr_o), 64'h40);
      chk("bp_noflush", 64'(flush_o), 64'd0);
    end
    bru_jump_flag_i = 1'b0;
    redirect_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", 64'(busy_o), 64'd0);
    chk("bp_cnt", 64'(redirect_cnt_o), 64'd3);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Interrupt raised while busy
    @(negedge clk);
    bru_jump_flag_i = 1'b1; bru_jump_addr_i = 32'h0000_0500;
    push(32'h0000_0500);
    @(posedge clk); #1;
    bru_jump_flag_i = 1'b0;
    int_req_i = 1'b1; int_addr_i = 32'h0000_2000;
    push(32'h0000_2000);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ib_no_ack", 64'(int_ack_o), 64'd0);
      chk("ib_busy", 64'(busy_o), 64'd1);
      @(posedge clk); #2;
    end
    chk("ib_idle", 64'(busy_o), 64'd0);
    chk("ib_ack", 64'(int_ack_o), 64'd1);
    @(posedge clk); #1;
    int_req_i = 1'b0;
    chk("ib_flush", 64'(flush_o), 64'd1);
    wait_idle("ib_done");
    chk("ib_cnt", 64'(redirect_cnt_o), 64'd5);

    // Odd target has bit 0 cleared
    run_bru(32'h0000_1235, 32'h0000_1234);

    // Reset while presenting a target
    @(negedge clk);
    redirect_ready_i = 1'b0;
    bru_jump_flag_i = 1'b1; bru_jump_addr_i = 32'h0000_3000;
    push(32'h0000_3000);
    @(posedge clk); #1;
    bru_jump_flag_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_valid", 64'(redirect_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    exp_q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    redirect_ready_i = 1'b1;
    run_bru(32'h0000_4000, 32'h0000_4000);

    // Handshake counter wraps
    @(negedge clk);
    force dut.rcnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.rcnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pre", 64'(redirect_cnt_o), 64'hFFFF_FFFF);
    run_bru(32'h0000_0800, 32'h0000_0800);
    chk("wrap_cnt", 64'(redirect_cnt_o), 64'd0);

    repeat (2) @(posedge clk);
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
